// File: rtl/btb_update_ctrl.sv
// BTB update controller: mispredict redirect plus a DEPTH-entry BTB write queue; redirect one cycle after resolve.
// Head is offered combinationally and pops when i_upd_ready; full queue drops updates. Macro BTB_UPD_COALESCE_EN merges same-pc updates.
module btb_update_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_res_valid,
    input  logic [31:0] i_res_pc,
    input  logic        i_res_taken,
    input  logic [31:0] i_res_target,
    input  logic        i_res_pred_valid,
    input  logic [31:0] i_res_pred_target,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    input  logic        i_upd_ready,
    output logic        o_upd_en,
    output logic [31:0] o_upd_addr,
    output logic [31:0] o_upd_target,
    output logic        o_full,
    output logic [7:0]  o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0] q_pc  [DEPTH];
    logic [31:0] q_tgt [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    logic mis_tk, mis_nt, empty, pop, accept, drop, hit;

    assign mis_tk = i_res_valid & i_res_taken &
                    (!i_res_pred_valid | (i_res_pred_target != i_res_target));
    assign mis_nt = i_res_valid & !i_res_taken & i_res_pred_valid;
    assign empty  = (count == '0);
    assign o_full = (count == DEPTH_C);
    assign pop    = !empty & i_upd_ready & !i_rst;

    assign o_upd_en     = pop;
    assign o_upd_addr   = empty ? 32'h0 : q_pc[rd_ptr];
    assign o_upd_target = empty ? 32'h0 : q_tgt[rd_ptr];

`ifdef BTB_UPD_COALESCE_EN
    logic [AW-1:0] hit_idx;

    // Only live entries match; the head is excluded when it leaves this cycle.
    always_comb begin
        logic [AW-1:0] off;
        hit     = 1'b0;
        hit_idx = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if (({1'b0, off} < count) && !(pop && (off == '0)) &&
                (q_pc[i] == i_res_pc)) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign accept = mis_tk & !hit & (!o_full | pop);
    assign drop   = mis_tk & !hit & o_full & !pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= 32'h0;
            o_drop_cnt    <= 8'h0;
        end else begin
            o_redirect <= mis_tk | mis_nt;
            if (mis_tk)
                o_redirect_pc <= i_res_target;
            else if (mis_nt)
                o_redirect_pc <= i_res_pc + 32'd4;

            if (accept) begin
                q_pc[wr_ptr]  <= i_res_pc;
                q_tgt[wr_ptr] <= i_res_target;
                wr_ptr        <= wr_ptr + 1'b1;
            end
`ifdef BTB_UPD_COALESCE_EN
            if (mis_tk && hit)
                q_tgt[hit_idx] <= i_res_target;
`endif
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

            if (drop && (o_drop_cnt != 8'hFF))
                o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios then random traffic, checked against a queue-based model.
module tb_btb_update_ctrl;
    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst, i_res_valid, i_res_taken, i_res_pred_valid, i_upd_ready;
    logic [31:0] i_res_pc, i_res_target, i_res_pred_target;
    logic        o_redirect, o_upd_en, o_full;
    logic [31:0] o_redirect_pc, o_upd_addr, o_upd_target;
    logic [7:0]  o_drop_cnt;

    btb_update_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_res_valid(i_res_valid), .i_res_pc(i_res_pc), .i_res_taken(i_res_taken),
        .i_res_target(i_res_target), .i_res_pred_valid(i_res_pred_valid),
        .i_res_pred_target(i_res_pred_target),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .i_upd_ready(i_upd_ready), .o_upd_en(o_upd_en), .o_upd_addr(o_upd_addr),
        .o_upd_target(o_upd_target), .o_full(o_full), .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: queue of {pc, target}, redirect register, drop counter.
    logic [63:0] mq[$];
    logic        m_redir = 1'b0;
    logic [31:0] m_rpc   = 32'h0;
    int          m_drop  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic pv, input logic [31:0] pt);
        i_res_valid = v; i_res_pc = pc; i_res_taken = tk;
        i_res_target = tgt; i_res_pred_valid = pv; i_res_pred_target = pt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic model_update();
        logic mt, mn, pop, hit;
        mt  = i_res_valid && i_res_taken && (!i_res_pred_valid || i_res_pred_target != i_res_target);
        mn  = i_res_valid && !i_res_taken && i_res_pred_valid;
        pop = (mq.size() > 0) && i_upd_ready;
        hit = 1'b0;
        if (i_rst) begin
            mq.delete();
            m_redir = 1'b0;
            m_rpc   = 32'h0;
            m_drop  = 0;
        end else begin
            m_redir = mt || mn;
            if (mt) m_rpc = i_res_target;
            else if (mn) m_rpc = i_res_pc + 32'd4;
            if (mt) begin
`ifdef BTB_UPD_COALESCE_EN
                for (int j = (pop ? 1 : 0); j < mq.size(); j++)
                    if (!hit && mq[j][63:32] == i_res_pc) begin
                        mq[j] = {i_res_pc, i_res_target};
                        hit = 1'b1;
                    end
`endif
                if (!hit) begin
                    if (mq.size() < DEPTH || pop) mq.push_back({i_res_pc, i_res_target});
                    else if (m_drop < 255) m_drop++;
                end
            end
            if (pop) void'(mq.pop_front());
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model, return just after the edge.
    task automatic step();
        logic [63:0] head;
        @(negedge i_clk);
        if (chk_en) begin
            head = (mq.size() > 0) ? mq[0] : 64'h0;
            chk("redirect", {31'h0, o_redirect}, {31'h0, m_redir});
            chk("redirect_pc", o_redirect_pc, m_rpc);
            chk("upd_en", {31'h0, o_upd_en},
                {31'h0, (mq.size() > 0) && i_upd_ready && !i_rst});
            chk("upd_addr", o_upd_addr, head[63:32]);
            chk("upd_target", o_upd_target, head[31:0]);
            chk("full", {31'h0, o_full}, {31'h0, mq.size() == DEPTH});
            chk("drop_cnt", {24'h0, o_drop_cnt}, 32'(m_drop));
        end
        model_update();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_upd_ready = 1'b0; idle();
        step();
        chk_en = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rst_redirect", {31'h0, o_redirect}, 32'h0);
        chk("rst_rpc", o_redirect_pc, 32'h0);
        chk("rst_drop", {24'h0, o_drop_cnt}, 32'h0);
        chk("rst_full", {31'h0, o_full}, 32'h0);

        // Single taken mispredict on a BTB miss.
        i_upd_ready = 1'b1;
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        step(); idle();
        chk("t1_redirect", {31'h0, o_redirect}, 32'h1);
        chk("t1_rpc", o_redirect_pc, 32'h200);
        chk("t1_upd_en", {31'h0, o_upd_en}, 32'h1);
        chk("t1_addr", o_upd_addr, 32'h100);
        chk("t1_tgt", o_upd_target, 32'h200);
        step();
        chk("t1_empty", {31'h0, o_upd_en}, 32'h0);

        // Not-taken mispredicts, including address wrap.
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h999);
        step(); idle();
        chk("nt_rpc", o_redirect_pc, 32'h304);
        chk("nt_noenq", {31'h0, o_upd_en}, 32'h0);
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h5);
        step(); idle();
        chk("nt_wrap", o_redirect_pc, 32'h0);
        step();
        chk("nt_hold_redir", {31'h0, o_redirect}, 32'h0);
        chk("nt_hold_rpc", o_redirect_pc, 32'h0);

        // Overflow with the write port stalled.
        i_upd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h1000 + 32'(16 * k), 1'b1, 32'h2000 + 32'(k), 1'b0, 32'h0);
            step();
            if (k == 3) chk("ovf_full4", {31'h0, o_full}, 32'h1);
        end
        idle();
        chk("ovf_drop", {24'h0, o_drop_cnt}, 32'h1);
        i_upd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ovf_order", o_upd_addr, 32'h1000 + 32'(16 * k));
            step();
        end
        chk("ovf_drained", {31'h0, o_upd_en}, 32'h0);

        // Enqueue into a full queue while it pops.
        i_upd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h500 + 32'(4 * k), 1'b1, 32'h900, 1'b0, 32'h0);
            step();
        end
        i_upd_ready = 1'b1;
        drive(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 32'h0);
        step(); idle();
        chk("fp_full", {31'h0, o_full}, 32'h1);
        chk("fp_drop", {24'h0, o_drop_cnt}, 32'h1);
        step(); step(); step();
        chk("fp_last", o_upd_addr, 32'h600);
        step();

        // Same pc twice while stalled.
        i_upd_ready = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
        step(); idle();
        i_upd_ready = 1'b1;
        chk("dup_addr", o_upd_addr, 32'h40);
`ifdef BTB_UPD_COALESCE_EN
        chk("dup_tgt", o_upd_target, 32'hC0);
        step();
`else
        chk("dup_tgt0", o_upd_target, 32'h80);
        step();
        chk("dup_tgt1", o_upd_target, 32'hC0);
        step();
`endif
        chk("dup_empty", {31'h0, o_upd_en}, 32'h0);

        // Reset with pending entries, then immediate traffic.
        i_upd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hA00 + 32'(4 * k), 1'b1, 32'hB00, 1'b0, 32'h0);
            step();
        end
        idle();
        i_rst = 1'b1; i_upd_ready = 1'b1;
        chk("rq_no_upd", {31'h0, o_upd_en}, 32'h0);
        step();
        i_rst = 1'b0;
        chk("rq_empty", {31'h0, o_upd_en}, 32'h0);
        chk("rq_addr", o_upd_addr, 32'h0);
        chk("rq_drop", {24'h0, o_drop_cnt}, 32'h0);
        drive(1'b1, 32'h700, 1'b1, 32'h740, 1'b0, 32'h0);
        step(); idle();
        chk("rq_first", {31'h0, o_redirect}, 32'h1);
        chk("rq_first_addr", o_upd_addr, 32'h700);

        // Random traffic with alternating drain-heavy and stall-heavy phases.
        for (int c = 0; c < 800; c++) begin
            logic [31:0] tgt;
            i_rst = ($urandom_range(0, 149) == 0);
            tgt   = 32'h8000 + 32'(4 * $urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 5)),
                  1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? tgt : 32'h8000 + 32'(4 * $urandom_range(0, 3)));
            i_upd_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            step();
        end
        i_rst = 1'b0; idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, update-queue entries (power of two, >=2).
REQ-002 SHALL have: i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have: i_rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have: i_res_valid  input  1  resolved branch from execute this cycle.
REQ-005 SHALL have: i_res_pc  input  32  address of resolved branch.
REQ-006 SHALL have: i_res_taken  input  1  actual direction.
REQ-007 SHALL have: i_res_target  input  32  actual taken target.
REQ-008 SHALL have: i_res_pred_valid  input  1  BTB hit recorded at fetch.
REQ-009 SHALL have: i_res_pred_target  input  32  BTB target recorded at fetch.
REQ-010 SHALL have: o_redirect  output  1  registered fetch redirect pulse.
REQ-011 SHALL have: o_redirect_pc  output  32  registered redirect address.
REQ-012 SHALL have: i_upd_ready  input  1  BTB write port granted this cycle.
REQ-013 SHALL have: o_upd_en, o_upd_addr (32), o_upd_target (32)  outputs  BTB write port.
REQ-014 SHALL have: o_full  output  1  queue holds DEPTH entries.
REQ-015 SHALL have: o_drop_cnt  output  8  saturating count of discarded updates.

Function
REQ-016 Mispredict-taken SHALL be i_res_valid & i_res_taken & (!i_res_pred_valid | i_res_pred_target != i_res_target).
REQ-017 Mispredict-not-taken SHALL be i_res_valid & !i_res_taken & i_res_pred_valid.
REQ-018 On either mispredict, o_redirect SHALL be 1 in the next cycle only; o_redirect_pc = i_res_target (taken) or i_res_pc + 32'd4 (not taken), 32-bit wrap.
REQ-019 o_redirect SHALL be 0 in any cycle not following a mispredict; o_redirect_pc holds its last value.
REQ-020 Mispredict-taken SHALL request enqueue of {i_res_pc, i_res_target} at tail; nothing else enqueues (no BTB invalidation on not-taken).
REQ-021 Queue SHALL be circular FIFO, DEPTH entries, read/write pointers wrapping at DEPTH, count 0..DEPTH.
REQ-022 o_upd_en SHALL be combinational (!empty & i_upd_ready); o_upd_addr/o_upd_target SHALL show head entry whenever non-empty, 0 when empty.
REQ-023 Head SHALL pop on the edge where o_upd_en=1; enqueued entry visible at head earliest one cycle after acceptance (no bypass).
REQ-024 Enqueue request when full and no pop that cycle SHALL be discarded and o_drop_cnt SHALL increment, saturating at 8'hFF.
REQ-025 Enqueue request when full with simultaneous pop SHALL be accepted; count unchanged.
REQ-026 Simultaneous enqueue and pop when count=1 SHALL leave count=1 with new entry at head.
REQ-027 o_full SHALL equal (count == DEPTH), registered-state derived.

Reset
REQ-028 On i_clk edge with i_rst=1: pointers and count 0, all entries invalid, o_redirect 0, o_redirect_pc 32'h0, o_drop_cnt 0.
REQ-029 i_rst SHALL override concurrent enqueue/pop; pending updates are lost, no o_upd_en while i_rst=1.
REQ-030 First cycle after i_rst deasserts SHALL accept i_res_valid normally.

Configuration
REQ-031 Macro BTB_UPD_COALESCE_EN SHALL select coalescing.
REQ-032 With BTB_UPD_COALESCE_EN: enqueue whose pc equals a queued entry's pc (excluding one popping that cycle) SHALL overwrite that entry's target in place, no new entry, no drop even if full.
REQ-033 Without BTB_UPD_COALESCE_EN: duplicate pcs SHALL enqueue as separate entries, drained in order.

Verification
REQ-034 Reset, i_res_valid=1 taken, pc=0x100, target=0x200, pred_valid=0, i_upd_ready=1 -> cycle+1 o_redirect=1, pc 0x200; cycle+1 o_upd_en=1, addr 0x100, target 0x200; then empty.
REQ-035 Not-taken pc=0x300 with pred_valid=1 -> o_redirect_pc=0x304, no enqueue; pc=0xFFFFFFFC -> 0x00000000.
REQ-036 i_upd_ready=0, 5 distinct taken mispredicts (DEPTH=4) -> o_full=1 after 4th, o_drop_cnt=1, drain order matches first 4 pcs.
REQ-037 Full queue, i_upd_ready=1, new mispredict same cycle -> accepted, o_drop_cnt unchanged, o_full stays 1.
REQ-038 BTB_UPD_COALESCE_EN, i_upd_ready=0, pc=0x40 target 0x80 then pc=0x40 target 0xC0 -> one entry, drains 0x40/0xC0; without macro -> two entries 0x80 then 0xC0.
REQ-039 i_rst=1 with 3 queued entries -> next cycle empty, o_upd_en=0, o_drop_cnt=0.
